// File: rtl/cpu_pkg.sv
// ============================================================================
// Module      : cpu_pkg
// Description : Shared CPU definitions for the instruction-fetch stage:
//               fetch FSM state encoding, IF/ID update selector, NOP word and
//               default address/data widths.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int unsigned CPU_ADDR_W   = 32;
    localparam int unsigned CPU_DATA_W   = 32;
    localparam logic [31:0] CPU_NOP_INST = 32'h0000_0000;

    // Fetch controller states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,   // no fetch in progress
        FETCH   = 2'd1,   // request outstanding for the current PC
        WAIT_ID = 2'd2,   // fetched word parked, ID stage stalled
        DRAIN   = 2'd3    // in-flight fetch will be discarded on ack
    } fetch_state_e;

    // What the IF/ID register does on the coming edge
    typedef enum logic [1:0] {
        IFID_BUBBLE   = 2'd0,
        IFID_HOLD     = 2'd1,
        IFID_LOAD_MEM = 2'd2,
        IFID_LOAD_BUF = 2'd3
    } ifid_op_e;

endpackage : cpu_pkg

`default_nettype wire

// File: rtl/if_inst_buf.sv
// ============================================================================
// Module      : if_inst_buf
// Description : Single-entry {pc, inst} holding buffer. Parks a fetched word
//               while the ID stage is stalled. Load has priority over clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_inst_buf #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [ADDR_W-1:0] i_pc,
    input  logic [DATA_W-1:0] i_inst,
    output logic              o_valid,
    output logic [ADDR_W-1:0] o_pc,
    output logic [DATA_W-1:0] o_inst
);

    logic              r_valid;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_inst;

    // Capture a word on load; drop the valid flag on clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_inst  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_pc    <= i_pc;
            r_inst  <= i_inst;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_pc    = r_pc;
    assign o_inst  = r_inst;

endmodule : if_inst_buf

`default_nettype wire

// File: rtl/if_fetch_stage.sv
// ============================================================================
// Module      : if_fetch_stage
// Description : Instruction-fetch stage. Runs the req/ack handshake to the
//               instruction memory for the current PC, writes the IF/ID
//               pipeline register and holds the PC until a fetch retires.
//               A fetch that is in flight when a branch flushes is drained
//               (address kept stable until ack) and its word discarded.
// Options     : `define IF_PERF_EN adds saturating perf counters
//               perf_fetch_o / perf_wait_o / perf_flush_o.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_fetch_stage
    import cpu_pkg::*;
#(
    parameter int unsigned        ADDR_W   = CPU_ADDR_W,
    parameter int unsigned        DATA_W   = CPU_DATA_W,
    parameter logic [DATA_W-1:0]  NOP_INST = DATA_W'(CPU_NOP_INST),
    parameter int unsigned        PERF_W   = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic              pc_hold_o,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [DATA_W-1:0] imem_data_i,
    output logic              ifid_valid_o,
    output logic [ADDR_W-1:0] ifid_pc_o,
    output logic [ADDR_W-1:0] ifid_pc4_o,
    output logic [DATA_W-1:0] ifid_inst_o
`ifdef IF_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_fetch_o,
    output logic [PERF_W-1:0] perf_wait_o,
    output logic [PERF_W-1:0] perf_flush_o
`endif
);

    localparam logic [ADDR_W-1:0] c_PC_INC = ADDR_W'(4);

    fetch_state_e      r_state;
    fetch_state_e      w_state_nxt;
    ifid_op_e          w_ifid_op;
    logic              w_pc_hold;
    logic              w_buf_load;
    logic              w_buf_clear;
    logic              w_drain_load;
    logic [ADDR_W-1:0] r_drain_addr;

    logic              r_ifid_valid;
    logic [ADDR_W-1:0] r_ifid_pc;
    logic [ADDR_W-1:0] r_ifid_pc4;
    logic [DATA_W-1:0] r_ifid_inst;

    logic              w_buf_valid;
    logic [ADDR_W-1:0] w_buf_pc;
    logic [DATA_W-1:0] w_buf_inst;

    // Word parked while ID is stalled at the moment of ack
    if_inst_buf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_inst_buf (
        .clk     (clk_i),
        .rst     (rst_i),
        .i_load  (w_buf_load),
        .i_clear (w_buf_clear),
        .i_pc    (pc_i),
        .i_inst  (imem_data_i),
        .o_valid (w_buf_valid),
        .o_pc    (w_buf_pc),
        .o_inst  (w_buf_inst)
    );

    // Next state, PC hold and IF/ID update decision for this cycle
    always_comb begin
        w_state_nxt  = r_state;
        w_ifid_op    = IFID_BUBBLE;
        w_pc_hold    = 1'b1;
        w_buf_load   = 1'b0;
        w_buf_clear  = 1'b0;
        w_drain_load = 1'b0;
        case (r_state)
            IDLE: begin
                if (stall_i && !flush_i) w_ifid_op = IFID_HOLD;
                if (start_i)             w_state_nxt = FETCH;
            end
            FETCH: begin
                if (imem_ack_i) begin
                    if (flush_i) begin
                        // Word belongs to the wrong path; PC takes the target
                        w_pc_hold = 1'b0;
                    end else if (stall_i) begin
                        // ID cannot accept: park word, keep PC on it
                        w_ifid_op   = IFID_HOLD;
                        w_buf_load  = 1'b1;
                        w_state_nxt = WAIT_ID;
                    end else begin
                        w_ifid_op   = IFID_LOAD_MEM;
                        w_pc_hold   = 1'b0;
                        w_state_nxt = start_i ? FETCH : IDLE;
                    end
                end else begin
                    if (flush_i) begin
                        // Request must stay stable until ack, so drain it
                        w_drain_load = 1'b1;
                        w_pc_hold    = 1'b0;
                        w_state_nxt  = DRAIN;
                    end else begin
                        if (stall_i) w_ifid_op = IFID_HOLD;
                        if (!start_i) begin
                            w_drain_load = 1'b1;
                            w_state_nxt  = DRAIN;
                        end
                    end
                end
            end
            WAIT_ID: begin
                if (flush_i) begin
                    w_buf_clear = 1'b1;
                    w_pc_hold   = 1'b0;
                    w_state_nxt = FETCH;
                end else if (!stall_i) begin
                    w_ifid_op   = IFID_LOAD_BUF;
                    w_buf_clear = 1'b1;
                    w_pc_hold   = 1'b0;
                    w_state_nxt = FETCH;
                end else begin
                    w_ifid_op = IFID_HOLD;
                end
            end
            DRAIN: begin
                w_pc_hold = !flush_i;
                if (stall_i && !flush_i) w_ifid_op = IFID_HOLD;
                if (imem_ack_i)          w_state_nxt = start_i ? FETCH : IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, drain address and IF/ID pipeline register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= IDLE;
            r_drain_addr <= '0;
            r_ifid_valid <= 1'b0;
            r_ifid_pc    <= '0;
            r_ifid_pc4   <= c_PC_INC;
            r_ifid_inst  <= NOP_INST;
        end else begin
            r_state <= w_state_nxt;
            if (w_drain_load) r_drain_addr <= pc_i;
            case (w_ifid_op)
                IFID_HOLD: begin
                end
                IFID_LOAD_MEM: begin
                    r_ifid_valid <= 1'b1;
                    r_ifid_pc    <= pc_i;
                    r_ifid_pc4   <= pc_i + c_PC_INC;
                    r_ifid_inst  <= imem_data_i;
                end
                IFID_LOAD_BUF: begin
                    r_ifid_valid <= w_buf_valid;
                    r_ifid_pc    <= w_buf_pc;
                    r_ifid_pc4   <= w_buf_pc + c_PC_INC;
                    r_ifid_inst  <= w_buf_inst;
                end
                default: begin
                    // Bubble: pc fields keep their previous value
                    r_ifid_valid <= 1'b0;
                    r_ifid_inst  <= NOP_INST;
                end
            endcase
        end
    end

`ifdef IF_PERF_EN
    logic [PERF_W-1:0] r_perf_fetch;
    logic [PERF_W-1:0] r_perf_wait;
    logic [PERF_W-1:0] r_perf_flush;
    logic              w_inc_fetch;
    logic              w_inc_wait;
    logic              w_inc_flush;

    assign w_inc_fetch = (w_ifid_op == IFID_LOAD_MEM) || (w_ifid_op == IFID_LOAD_BUF);
    assign w_inc_wait  = (r_state == FETCH) && !imem_ack_i;
    // A flush discards a word when it hits a live fetch or a parked word;
    // a flush during DRAIN hits a word that is already being discarded.
    assign w_inc_flush = flush_i && ((r_state == FETCH) || (r_state == WAIT_ID));

    // Saturating event counters
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_perf_fetch <= '0;
            r_perf_wait  <= '0;
            r_perf_flush <= '0;
        end else begin
            if (w_inc_fetch && (r_perf_fetch != '1)) r_perf_fetch <= r_perf_fetch + 1'b1;
            if (w_inc_wait  && (r_perf_wait  != '1)) r_perf_wait  <= r_perf_wait + 1'b1;
            if (w_inc_flush && (r_perf_flush != '1)) r_perf_flush <= r_perf_flush + 1'b1;
        end
    end

    assign perf_fetch_o = r_perf_fetch;
    assign perf_wait_o  = r_perf_wait;
    assign perf_flush_o = r_perf_flush;
`endif

    assign pc_hold_o    = w_pc_hold;
    assign imem_req_o   = (r_state == FETCH) || (r_state == DRAIN);
    assign imem_addr_o  = (r_state == DRAIN) ? r_drain_addr : pc_i;
    assign ifid_valid_o = r_ifid_valid;
    assign ifid_pc_o    = r_ifid_pc;
    assign ifid_pc4_o   = r_ifid_pc4;
    assign ifid_inst_o  = r_ifid_inst;

endmodule : if_fetch_stage

`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
// ============================================================================
// Module      : tb_if_fetch_stage
// Description : Directed self-checking bench for if_fetch_stage. Models the
//               PC register (advances by 4 or loads the branch target when
//               pc_hold_o is low) and drives the memory ack by hand.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_fetch_stage;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [31:0] pc_i;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        pc_hold_o;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_data_i = 32'h0;
    logic        ifid_valid_o;
    logic [31:0] ifid_pc_o;
    logic [31:0] ifid_pc4_o;
    logic [31:0] ifid_inst_o;
`ifdef IF_PERF_EN
    logic [31:0] perf_fetch_o;
    logic [31:0] perf_wait_o;
    logic [31:0] perf_flush_o;
`endif

    logic [31:0] pc_rst_val = 32'h0;
    logic [31:0] flush_tgt  = 32'h0;
    int          checks = 0;
    int          errors = 0;

    if_fetch_stage dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .pc_i         (pc_i),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .pc_hold_o    (pc_hold_o),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_ack_i   (imem_ack_i),
        .imem_data_i  (imem_data_i),
        .ifid_valid_o (ifid_valid_o),
        .ifid_pc_o    (ifid_pc_o),
        .ifid_pc4_o   (ifid_pc4_o),
        .ifid_inst_o  (ifid_inst_o)
`ifdef IF_PERF_EN
        ,
        .perf_fetch_o (perf_fetch_o),
        .perf_wait_o  (perf_wait_o),
        .perf_flush_o (perf_flush_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // PC register with stall-hold and branch-target load
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)           pc_i <= pc_rst_val;
        else if (!pc_hold_o) pc_i <= flush_i ? flush_tgt : pc_i + 32'd4;
    end

    function automatic logic [31:0] dat(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset(input logic [31:0] pcv);
        pc_rst_val = pcv;
        start_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0; imem_ack_i = 1'b0;
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(32'h0);
        @(negedge clk_i);
        checks++; if (imem_req_o !== 1'b0)   begin errors++; $display("FAIL rst_req got %b exp 0", imem_req_o); end
        checks++; if (ifid_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", ifid_valid_o); end
        checks++; if (ifid_pc4_o !== 32'h4)  begin errors++; $display("FAIL rst_pc4 got %h exp 4", ifid_pc4_o); end
        checks++; if (pc_hold_o !== 1'b1)    begin errors++; $display("FAIL rst_hold got %b exp 1", pc_hold_o); end
        // Load one instruction, then reset while the next request is open
        start_i = 1'b1;
        tick();
        imem_ack_i = 1'b1; imem_data_i = dat(32'h0);
        tick();
        imem_ack_i = 1'b0;
        @(negedge clk_i);
        checks++; if (imem_req_o !== 1'b1 || ifid_valid_o !== 1'b1) begin errors++; $display("FAIL pre_rst req/valid got %b%b exp 11", imem_req_o, ifid_valid_o); end
        rst_i = 1'b1;
        tick();
        @(negedge clk_i);
        checks++; if (imem_req_o !== 1'b0)        begin errors++; $display("FAIL midrst_req got %b exp 0", imem_req_o); end
        checks++; if (ifid_valid_o !== 1'b0)      begin errors++; $display("FAIL midrst_valid got %b exp 0", ifid_valid_o); end
        checks++; if (ifid_inst_o !== 32'h0)      begin errors++; $display("FAIL midrst_inst got %h exp 0", ifid_inst_o); end
        checks++; if (pc_hold_o !== 1'b1)         begin errors++; $display("FAIL midrst_hold got %b exp 1", pc_hold_o); end
        checks++; if (ifid_pc_o !== 32'h0)        begin errors++; $display("FAIL midrst_pc got %h exp 0", ifid_pc_o); end
        rst_i = 1'b0;
    endtask

    task automatic test_zero_wait();
        do_reset(32'h0);
        start_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            imem_ack_i = 1'b1; imem_data_i = dat(32'(4 * i));
            if (i == 2) start_i = 1'b0;
            @(negedge clk_i);
            checks++; if (imem_addr_o !== 32'(4 * i)) begin errors++; $display("FAIL zw_addr%0d got %h exp %h", i, imem_addr_o, 4 * i); end
            checks++; if (pc_hold_o !== 1'b0)         begin errors++; $display("FAIL zw_hold%0d got %b exp 0", i, pc_hold_o); end
            if (i > 0) begin
                checks++; if (ifid_pc_o !== 32'(4 * (i - 1)) || ifid_valid_o !== 1'b1) begin errors++; $display("FAIL zw_ifid%0d got %h/%b exp %h/1", i, ifid_pc_o, ifid_valid_o, 4 * (i - 1)); end
            end
        end
        tick();
        imem_ack_i = 1'b0;
        @(negedge clk_i);
        checks++; if (ifid_pc_o !== 32'h8 || ifid_pc4_o !== 32'hC) begin errors++; $display("FAIL zw_last pc/pc4 got %h/%h exp 8/c", ifid_pc_o, ifid_pc4_o); end
        checks++; if (ifid_inst_o !== dat(32'h8))                  begin errors++; $display("FAIL zw_inst got %h exp %h", ifid_inst_o, dat(32'h8)); end
        checks++; if (imem_req_o !== 1'b0)                         begin errors++; $display("FAIL zw_idle_req got %b exp 0", imem_req_o); end
    endtask

    task automatic test_wait_states();
        do_reset(32'h10);
        start_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            @(negedge clk_i);
            checks++; if (pc_hold_o !== 1'b1 || imem_req_o !== 1'b1) begin errors++; $display("FAIL ws_hold/req%0d got %b%b exp 11", k, pc_hold_o, imem_req_o); end
            checks++; if (imem_addr_o !== 32'h10)                    begin errors++; $display("FAIL ws_addr%0d got %h exp 10", k, imem_addr_o); end
            checks++; if (ifid_valid_o !== 1'b0)                     begin errors++; $display("FAIL ws_bubble%0d got %b exp 0", k, ifid_valid_o); end
        end
        tick();
        imem_ack_i = 1'b1; imem_data_i = dat(32'h10); start_i = 1'b0;
        @(negedge clk_i);
        checks++; if (pc_hold_o !== 1'b0) begin errors++; $display("FAIL ws_ack_hold got %b exp 0", pc_hold_o); end
        tick();
        imem_ack_i = 1'b0;
        @(negedge clk_i);
        checks++; if (ifid_pc_o !== 32'h10 || ifid_valid_o !== 1'b1) begin errors++; $display("FAIL ws_ifid got %h/%b exp 10/1", ifid_pc_o, ifid_valid_o); end
        checks++; if (ifid_inst_o !== dat(32'h10))                   begin errors++; $display("FAIL ws_inst got %h exp %h", ifid_inst_o, dat(32'h10)); end
`ifdef IF_PERF_EN
        checks++; if (perf_wait_o !== 32'd3)  begin errors++; $display("FAIL ws_perf_wait got %0d exp 3", perf_wait_o); end
        checks++; if (perf_fetch_o !== 32'd1) begin errors++; $display("FAIL ws_perf_fetch got %0d exp 1", perf_fetch_o); end
`endif
    endtask

    task automatic test_stall_on_ack();
        do_reset(32'h1C);
        start_i = 1'b1;
        tick();
        imem_ack_i = 1'b1; imem_data_i = dat(32'h1C);
        tick();
        imem_data_i = dat(32'h20); stall_i = 1'b1;
        @(negedge clk_i);
        checks++; if (pc_hold_o !== 1'b1 || imem_addr_o !== 32'h20) begin errors++; $display("FAIL st_ack hold/addr got %b/%h exp 1/20", pc_hold_o, imem_addr_o); end
        tick();
        imem_ack_i = 1'b0;
        @(negedge clk_i);
        checks++; if (imem_req_o !== 1'b0 || pc_hold_o !== 1'b1)    begin errors++; $display("FAIL st_wait req/hold got %b%b exp 01", imem_req_o, pc_hold_o); end
        checks++; if (ifid_pc_o !== 32'h1C || ifid_valid_o !== 1'b1) begin errors++; $display("FAIL st_hold_ifid got %h/%b exp 1c/1", ifid_pc_o, ifid_valid_o); end
        tick();
        stall_i = 1'b0; start_i = 1'b0;
        @(negedge clk_i);
        checks++; if (pc_hold_o !== 1'b0 || ifid_pc_o !== 32'h1C) begin errors++; $display("FAIL st_release hold/pc got %b/%h exp 0/1c", pc_hold_o, ifid_pc_o); end
        tick();
        @(negedge clk_i);
        checks++; if (ifid_pc_o !== 32'h20 || ifid_inst_o !== dat(32'h20)) begin errors++; $display("FAIL st_enter got %h/%h exp 20/%h", ifid_pc_o, ifid_inst_o, dat(32'h20)); end
        checks++; if (ifid_pc4_o !== 32'h24)                              begin errors++; $display("FAIL st_pc4 got %h exp 24", ifid_pc4_o); end
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h24)      begin errors++; $display("FAIL st_nextreq got %b/%h exp 1/24", imem_req_o, imem_addr_o); end
    endtask

    task automatic test_flush_drain();
        do_reset(32'h30);
        start_i = 1'b1;
        tick();
        @(negedge clk_i);
        checks++; if (imem_addr_o !== 32'h30 || pc_hold_o !== 1'b1) begin errors++; $display("FAIL fl_pre addr/hold got %h/%b exp 30/1", imem_addr_o, pc_hold_o); end
        tick();
        flush_i = 1'b1; flush_tgt = 32'h100;
        @(negedge clk_i);
        checks++; if (pc_hold_o !== 1'b0) begin errors++; $display("FAIL fl_hold got %b exp 0", pc_hold_o); end
        tick();
        flush_i = 1'b0;
        @(negedge clk_i);
        checks++; if (imem_addr_o !== 32'h30 || imem_req_o !== 1'b1) begin errors++; $display("FAIL fl_drain addr/req got %h/%b exp 30/1", imem_addr_o, imem_req_o); end
        checks++; if (pc_hold_o !== 1'b1 || pc_i !== 32'h100)         begin errors++; $display("FAIL fl_drain hold/pc got %b/%h exp 1/100", pc_hold_o, pc_i); end
        tick();
        imem_ack_i = 1'b1; imem_data_i = dat(32'h30);
        @(negedge clk_i);
        checks++; if (imem_addr_o !== 32'h30) begin errors++; $display("FAIL fl_ack_addr got %h exp 30", imem_addr_o); end
        tick();
        imem_data_i = dat(32'h100); start_i = 1'b0;
        @(negedge clk_i);
        checks++; if (imem_addr_o !== 32'h100 || ifid_valid_o !== 1'b0) begin errors++; $display("FAIL fl_retarget addr/valid got %h/%b exp 100/0", imem_addr_o, ifid_valid_o); end
        tick();
        imem_ack_i = 1'b0;
        @(negedge clk_i);
        checks++; if (ifid_pc_o !== 32'h100 || ifid_inst_o !== dat(32'h100)) begin errors++; $display("FAIL fl_target got %h/%h exp 100/%h", ifid_pc_o, ifid_inst_o, dat(32'h100)); end
`ifdef IF_PERF_EN
        checks++; if (perf_flush_o !== 32'd1) begin errors++; $display("FAIL fl_perf_flush got %0d exp 1", perf_flush_o); end
        checks++; if (perf_wait_o !== 32'd2)  begin errors++; $display("FAIL fl_perf_wait got %0d exp 2", perf_wait_o); end
`endif
    endtask

    task automatic test_wrap();
        do_reset(32'hFFFF_FFFC);
        start_i = 1'b1;
        tick();
        imem_ack_i = 1'b1; imem_data_i = dat(32'hFFFF_FFFC); start_i = 1'b0;
        tick();
        imem_ack_i = 1'b0;
        @(negedge clk_i);
        checks++; if (ifid_pc_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc got %h exp fffffffc", ifid_pc_o); end
        checks++; if (ifid_pc4_o !== 32'h0)        begin errors++; $display("FAIL wrap_pc4 got %h exp 0", ifid_pc4_o); end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall_on_ack();
        test_flush_drain();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_if_fetch_stage

`default_nettype wire
